// File: rtl/usb_fs_pkg.sv
// rtl/usb_fs_pkg.sv - shared encodings, states and constants for the full-speed USB receiver
package usb_fs_pkg;

  localparam int BIT_RATE_MHZ = 12;

  // Encodings match the raw {linep, linem} pair so the input stage is a straight copy.
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP,
    S_ERR
  } state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_STUFF = 3'd1;
  localparam logic [2:0] ERR_ALIGN = 3'd2;
  localparam logic [2:0] ERR_SE1   = 3'd3;
  localparam logic [2:0] ERR_SYNC  = 3'd4;
  localparam logic [2:0] ERR_EOP   = 3'd5;

  // Decoded SYNC bits, first-received bit in position 0: seven 0s then a 1.
  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

  // Anything that is not a clean J, K or SE0 (including X/Z) is treated as SE1.
  function automatic line_t decode_line(input logic p, input logic m);
    case ({p, m})
      2'b10:   return LS_J;
      2'b01:   return LS_K;
      2'b00:   return LS_SE0;
      default: return LS_SE1;
    endcase
  endfunction

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// rtl/usb_nrzi_unstuff.sv - NRZI decode with ones counting and stuffed-bit removal
module usb_nrzi_unstuff
  import usb_fs_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  track,
  input  line_t line,
  output logic  bit_val,
  output logic  bit_en,
  output logic  stuff_err
);

  line_t      prev;
  logic [2:0] ones;
  logic       is_jk;
  logic       stuff_slot;

  // Decode the current sample; the bit after six 1s is never delivered.
  always_comb begin
    is_jk      = (line == LS_J) || (line == LS_K);
    stuff_slot = (ones == 3'd6);
    bit_val    = (line == prev);
    bit_en     = track && is_jk && !stuff_slot;
    stuff_err  = track && is_jk && stuff_slot && bit_val;
  end

  // Previous J/K level and run of decoded 1s; both restart whenever not tracking a packet.
  always_ff @(posedge clk) begin
    if (reset || !track) begin
      prev <= LS_J;
      ones <= 3'd0;
    end else if (is_jk) begin
      prev <= line;
      if (stuff_slot || !bit_val) ones <= 3'd0;
      else                        ones <= ones + 3'd1;
    end
  end

endmodule

// File: rtl/usb_fs_rx.sv
// rtl/usb_fs_rx.sv - full-speed USB receive front end: SYNC, bytes, EOP, errors, bus reset
module usb_fs_rx
  import usb_fs_pkg::*;
#(
  parameter int RESET_BITS = BIT_RATE_MHZ * 5 / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       linep,
  input  logic       linem,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       rx_pid_err,
  output logic       rx_eop,
  output logic       rx_err,
  output logic [2:0] rx_err_code,
  output logic       bus_reset
);

  localparam int            RW      = $clog2(RESET_BITS + 1);
  localparam logic [RW-1:0] RST_MAX = RW'(RESET_BITS);

  line_t         line_q;
  state_t        state, state_n;
  logic [2:0]    sync_cnt, sync_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          first_pend, first_pend_n;
  logic [1:0]    se0_cnt, se0_cnt_n;
  logic [RW-1:0] rst_cnt, rst_cnt_n;
  logic          active_n, valid_n, first_n, pid_err_n, eop_n, err_n, bus_reset_n;
  logic [7:0]    data_n;
  logic [2:0]    code_n;
  logic          abort;
  logic [2:0]    abort_code;
  logic          track, bit_val, bit_en, stuff_err;

  // Register the bus pair once per bit.
  always_ff @(posedge clk) begin
    if (reset) line_q <= LS_J;
    else       line_q <= decode_line(linep, linem);
  end

  // The entry K of SYNC is decoded while still in IDLE so it counts as the first SYNC bit.
  assign track = (state == S_SYNC) || (state == S_DATA) ||
                 ((state == S_IDLE) && (line_q == LS_K));

  usb_nrzi_unstuff u_nrzi (
    .clk       (clk),
    .reset     (reset),
    .track     (track),
    .line      (line_q),
    .bit_val   (bit_val),
    .bit_en    (bit_en),
    .stuff_err (stuff_err)
  );

  // Packet FSM next state, byte assembly and next values of all registered outputs.
  always_comb begin
    state_n      = state;
    sync_cnt_n   = sync_cnt;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    first_pend_n = first_pend;
    se0_cnt_n    = se0_cnt;
    active_n     = rx_active;
    data_n       = rx_data;
    valid_n      = 1'b0;
    first_n      = 1'b0;
    pid_err_n    = 1'b0;
    eop_n        = 1'b0;
    err_n        = 1'b0;
    code_n       = rx_err_code;
    abort        = 1'b0;
    abort_code   = ERR_NONE;
    rst_cnt_n    = '0;
    bus_reset_n  = 1'b0;

    case (state)
      S_IDLE: begin
        if (line_q == LS_K) begin
          state_n    = S_SYNC;
          sync_cnt_n = 3'd1;
        end
        if (line_q == LS_SE0) begin
          rst_cnt_n   = (rst_cnt == RST_MAX) ? rst_cnt : rst_cnt + RW'(1);
          bus_reset_n = (rst_cnt_n == RST_MAX);
        end
      end
      S_SYNC: begin
        if (!bit_en || (bit_val != SYNC_PATTERN[sync_cnt])) begin
          abort      = 1'b1;
          abort_code = ERR_SYNC;
        end else if (sync_cnt == 3'd7) begin
          state_n      = S_DATA;
          active_n     = 1'b1;
          bit_cnt_n    = 3'd0;
          first_pend_n = 1'b1;
        end else begin
          sync_cnt_n = sync_cnt + 3'd1;
        end
      end
      S_DATA: begin
        if (line_q == LS_SE0) begin
          if (bit_cnt != 3'd0) begin
            abort      = 1'b1;
            abort_code = ERR_ALIGN;
          end else begin
            state_n   = S_EOP;
            se0_cnt_n = 2'd1;
          end
        end else if (line_q == LS_SE1) begin
          abort      = 1'b1;
          abort_code = ERR_SE1;
        end else if (stuff_err) begin
          abort      = 1'b1;
          abort_code = ERR_STUFF;
        end else if (bit_en) begin
          shift_n   = {bit_val, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            valid_n      = 1'b1;
            data_n       = shift_n;
            first_n      = first_pend;
            pid_err_n    = first_pend && (shift_n[7:4] != ~shift_n[3:0]);
            first_pend_n = 1'b0;
          end
        end
      end
      S_EOP: begin
        if (line_q == LS_SE0) begin
          if (se0_cnt == 2'd3) begin
            abort      = 1'b1;
            abort_code = ERR_EOP;
          end else begin
            se0_cnt_n = se0_cnt + 2'd1;
          end
        end else if (line_q == LS_J) begin
          eop_n    = 1'b1;
          active_n = 1'b0;
          state_n  = S_IDLE;
        end else begin
          abort      = 1'b1;
          abort_code = ERR_EOP;
        end
      end
      S_ERR: begin
        if (line_q == LS_J) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (abort) begin
      state_n  = S_ERR;
      err_n    = 1'b1;
      code_n   = abort_code;
      active_n = 1'b0;
    end
  end

  // State and output registers; reset discards any partial packet silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      sync_cnt    <= 3'd0;
      bit_cnt     <= 3'd0;
      shift       <= 8'd0;
      first_pend  <= 1'b0;
      se0_cnt     <= 2'd0;
      rst_cnt     <= '0;
      rx_active   <= 1'b0;
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      rx_first    <= 1'b0;
      rx_pid_err  <= 1'b0;
      rx_eop      <= 1'b0;
      rx_err      <= 1'b0;
      rx_err_code <= ERR_NONE;
      bus_reset   <= 1'b0;
    end else begin
      state       <= state_n;
      sync_cnt    <= sync_cnt_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      first_pend  <= first_pend_n;
      se0_cnt     <= se0_cnt_n;
      rst_cnt     <= rst_cnt_n;
      rx_active   <= active_n;
      rx_data     <= data_n;
      rx_valid    <= valid_n;
      rx_first    <= first_n;
      rx_pid_err  <= pid_err_n;
      rx_eop      <= eop_n;
      rx_err      <= err_n;
      rx_err_code <= code_n;
      bus_reset   <= bus_reset_n;
    end
  end

endmodule

// File: tb/tb_usb_fs_rx.sv
// tb/tb_usb_fs_rx.sv - self-checking bench for usb_fs_rx against a packet-level line model
module tb_usb_fs_rx;

  localparam int RESET_BITS = 30;
  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] K = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       first;
    logic       perr;
  } bev_t;

  typedef struct {
    int         cyc;
    logic [2:0] code;
  } eev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       linep, linem;
  logic       rx_active, rx_valid, rx_first, rx_pid_err, rx_eop, rx_err, bus_reset;
  logic [7:0] rx_data;
  logic [2:0] rx_err_code;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bev_t got_b[$], exp_b[$];
  eev_t got_e[$], exp_e[$];
  int   got_eop[$], exp_eop[$];
  int   got_rise[$], exp_rise[$], got_fall[$], exp_fall[$];
  int   got_brr[$], exp_brr[$], got_brf[$], exp_brf[$];

  logic [7:0] pk[$];
  logic [1:0] ls[$];
  int         last_idx[$];
  int         viol_idx, eop_idx, se0_idx;
  logic       cur_j;

  usb_fs_rx #(.RESET_BITS(RESET_BITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .linep       (linep),
    .linem       (linem),
    .rx_active   (rx_active),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_first    (rx_first),
    .rx_pid_err  (rx_pid_err),
    .rx_eop      (rx_eop),
    .rx_err      (rx_err),
    .rx_err_code (rx_err_code),
    .bus_reset   (bus_reset)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bev_t mon_b;
  eev_t mon_e;
  logic act_q = 1'b0;
  logic br_q = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      mon_b.cyc = cyc; mon_b.data = rx_data; mon_b.first = rx_first; mon_b.perr = rx_pid_err;
      got_b.push_back(mon_b);
    end
    if (rx_err) begin
      mon_e.cyc = cyc; mon_e.code = rx_err_code;
      got_e.push_back(mon_e);
    end
    if (rx_eop) got_eop.push_back(cyc);
    if (rx_active && !act_q) got_rise.push_back(cyc);
    if (!rx_active && act_q) got_fall.push_back(cyc);
    if (bus_reset && !br_q) got_brr.push_back(cyc);
    if (!bus_reset && br_q) got_brf.push_back(cyc);
    act_q = rx_active;
    br_q  = bus_reset;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bev_t mk(input int c, input logic [7:0] d, input logic f, input logic p);
    bev_t e;
    e.cyc = c; e.data = d; e.first = f; e.perr = p;
    return e;
  endfunction

  task automatic clear();
    got_b.delete(); exp_b.delete(); got_e.delete(); exp_e.delete();
    got_eop.delete(); exp_eop.delete(); got_rise.delete(); exp_rise.delete();
    got_fall.delete(); exp_fall.delete(); got_brr.delete(); exp_brr.delete();
    got_brf.delete(); exp_brf.delete();
  endtask

  task automatic put_bit(input logic b);
    if (!b) cur_j = !cur_j;
    ls.push_back(cur_j ? J : K);
  endtask

  // Transmitter model: SYNC, LSB-first bytes with stuffing after six 1s, NRZI, then SE0 SE0 J.
  // trunc >= 0 stops after that many data bits; drop = n omits the n-th stuff bit.
  task automatic encode(input int trunc, input int drop);
    int ones, nbits, nstuff;
    logic pend, bv;
    logic [7:0] cb;
    ls.delete(); last_idx.delete();
    viol_idx = -1; cur_j = 1'b1; pend = 1'b0;
    for (int i = 0; i < 7; i++) put_bit(1'b0);
    put_bit(1'b1);
    ones = 1; nbits = 0; nstuff = 0;
    foreach (pk[i]) begin
      cb = pk[i];
      for (int b = 0; b < 8; b++) begin
        if (trunc < 0 || nbits < trunc) begin
          bv = cb[b];
          put_bit(bv);
          if (pend && bv && viol_idx < 0) viol_idx = ls.size() - 1;
          pend = 1'b0;
          nbits++;
          if (b == 7) last_idx.push_back(ls.size() - 1);
          ones = bv ? ones + 1 : 0;
          if (ones == 6) begin
            nstuff++;
            if (nstuff == drop) pend = 1'b1;
            else put_bit(1'b0);
            ones = 0;
          end
        end
      end
    end
    se0_idx = ls.size();
    ls.push_back(SE0);
    ls.push_back(SE0);
    eop_idx = ls.size();
    for (int i = 0; i < 7; i++) ls.push_back(J);
  endtask

  task automatic send(output int c0);
    c0 = 0;
    for (int k = 0; k < ls.size(); k++) begin
      @(negedge clk);
      if (k == 0) c0 = cyc;
      {linep, linem} = ls[k];
    end
  endtask

  task automatic expect_bytes(input int c0, input int limit);
    logic [7:0] b;
    for (int i = 0; i < last_idx.size(); i++) begin
      if (last_idx[i] < limit) begin
        b = pk[i];
        exp_b.push_back(mk(c0 + last_idx[i] + 2, b, i == 0, (i == 0) && (b[7:4] != ~b[3:0])));
      end
    end
  endtask

  task automatic cmp_times(input string tag, input int g[$], input int e[$]);
    check({tag, " count"}, g.size(), e.size());
    for (int i = 0; i < g.size() && i < e.size(); i++) check({tag, " cyc"}, g[i], e[i]);
  endtask

  task automatic compare(input string nm);
    check({nm, " nbytes"}, got_b.size(), exp_b.size());
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
      check({nm, " data"}, got_b[i].data, exp_b[i].data);
      check({nm, " first"}, got_b[i].first, exp_b[i].first);
      check({nm, " pid_err"}, got_b[i].perr, exp_b[i].perr);
      check({nm, " valid_cyc"}, got_b[i].cyc, exp_b[i].cyc);
    end
    check({nm, " nerr"}, got_e.size(), exp_e.size());
    for (int i = 0; i < got_e.size() && i < exp_e.size(); i++) begin
      check({nm, " err_code"}, got_e[i].code, exp_e[i].code);
      check({nm, " err_cyc"}, got_e[i].cyc, exp_e[i].cyc);
    end
    cmp_times({nm, " eop"}, got_eop, exp_eop);
    cmp_times({nm, " act_rise"}, got_rise, exp_rise);
    cmp_times({nm, " act_fall"}, got_fall, exp_fall);
    cmp_times({nm, " busrst_rise"}, got_brr, exp_brr);
    cmp_times({nm, " busrst_fall"}, got_brf, exp_brf);
  endtask

  task automatic run_clean(input string nm);
    int c0;
    clear();
    encode(-1, 0);
    send(c0);
    expect_bytes(c0, ls.size());
    exp_eop.push_back(c0 + eop_idx + 2);
    exp_rise.push_back(c0 + 9);
    exp_fall.push_back(c0 + eop_idx + 2);
    compare(nm);
  endtask

  task automatic run_bus_reset(input int n, input string nm);
    int c0;
    clear();
    ls.delete();
    for (int i = 0; i < 3; i++) ls.push_back(J);
    for (int i = 0; i < n; i++) ls.push_back(SE0);
    for (int i = 0; i < 5; i++) ls.push_back(J);
    send(c0);
    if (n >= RESET_BITS) begin
      exp_brr.push_back(c0 + 3 + RESET_BITS - 1 + 2);
      exp_brf.push_back(c0 + 3 + n + 2);
    end
    compare(nm);
  endtask

  initial begin
    int c0, r, n;
    logic [7:0] nib;

    reset = 1'b1;
    {linep, linem} = J;
    repeat (3) @(negedge clk);
    check("reset rx_active", rx_active, 0);
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_first", rx_first, 0);
    check("reset rx_pid_err", rx_pid_err, 0);
    check("reset rx_eop", rx_eop, 0);
    check("reset rx_err", rx_err, 0);
    check("reset rx_err_code", rx_err_code, 0);
    check("reset bus_reset", bus_reset, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    pk.delete(); pk.push_back(8'hD2);
    run_clean("pid_d2");

    pk.delete(); pk.push_back(8'hC3); pk.push_back(8'hFF); pk.push_back(8'hFF);
    run_clean("stuffed");
    if (got_b.size() >= 2) check("stuffed late byte gap", got_b[1].cyc - got_b[0].cyc, 9);

    clear();
    encode(-1, 1);
    ls = ls[0:viol_idx];
    for (int i = 0; i < 6; i++) ls.push_back(J);
    send(c0);
    expect_bytes(c0, viol_idx);
    exp_e.push_back('{c0 + viol_idx + 2, 3'd1});
    exp_rise.push_back(c0 + 9);
    exp_fall.push_back(c0 + viol_idx + 2);
    compare("stuff_err");
    check("stuff_err code held", rx_err_code, 1);

    pk.delete(); pk.push_back(8'hD3); pk.push_back(8'h00);
    run_clean("pid_d3");

    clear();
    pk.delete(); pk.push_back(8'hA5); pk.push_back(8'($urandom));
    encode(12, 0);
    send(c0);
    expect_bytes(c0, se0_idx);
    exp_e.push_back('{c0 + se0_idx + 2, 3'd2});
    exp_rise.push_back(c0 + 9);
    exp_fall.push_back(c0 + se0_idx + 2);
    compare("align");
    check("align code held", rx_err_code, 2);

    run_bus_reset(RESET_BITS - 1, "busrst_29");
    run_bus_reset(RESET_BITS, "busrst_30");
    run_bus_reset(RESET_BITS + 6, "busrst_36");

    clear();
    pk.delete(); pk.push_back(8'h2D); pk.push_back(8'h5A); pk.push_back(8'h96);
    encode(-1, 0);
    ls = ls[0:last_idx[0] + 5];
    send(c0);
    @(negedge clk);
    reset = 1'b1;
    {linep, linem} = J;
    r = cyc;
    @(negedge clk);
    check("midrst rx_active", rx_active, 0);
    check("midrst rx_valid", rx_valid, 0);
    check("midrst rx_eop", rx_eop, 0);
    check("midrst rx_err", rx_err, 0);
    check("midrst rx_err_code", rx_err_code, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    exp_b.push_back(mk(c0 + last_idx[0] + 2, 8'h2D, 1'b1, 1'b0));
    exp_rise.push_back(c0 + 9);
    exp_fall.push_back(r + 1);
    compare("reset_mid");

    pk.delete(); pk.push_back(8'hE1); pk.push_back(8'h3C);
    run_clean("after_reset");

    for (int t = 0; t < 10; t++) begin
      nib = 8'($urandom_range(0, 15));
      pk.delete();
      if ($urandom_range(0, 3) == 0) pk.push_back(8'($urandom));
      else pk.push_back({~nib[3:0], nib[3:0]});
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) pk.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      run_clean($sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
